// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared FSM states and detector constants for seq_det_sched
package seq_det_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_CLEAR,
      S_SHIFT,
      S_DRAIN,
      S_RESP
   } state_e;

   localparam int DRAIN_CYC = 2;
   localparam int FLAG_LAT  = 2;

   // Serial pattern the shared detector recognises, oldest bit in the MSB.
   localparam logic [4:0] SEQ_PATTERN = 5'b10010;

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// rtl/seq_det_sched_rr_arbiter.sv - combinational round-robin grant starting at a pointer
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  gnt_id_o,
   output logic            any_o
);

   // Scan from the farthest offset down so the nearest valid requester wins last.
   always_comb begin
      int idx;
      idx      = 0;
      gnt_o    = '0;
      gnt_id_o = '0;
      any_o    = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = int'(ptr_i) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req_i[idx]) begin
            gnt_o      = '0;
            gnt_o[idx] = 1'b1;
            gnt_id_o   = idx[IDW-1:0];
            any_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - round-robin scheduler feeding one serial 10010 detector
// Optional first-match position output under SEQ_DET_SCHED_FIRSTPOS_EN.
module seq_det_sched
   import seq_det_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4,
   parameter int IDW    = $clog2(NREQ),
   parameter int KW     = $clog2(DATA_W)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     det_clr,
   output logic                     det_data,
   input  logic                     det_flag,
   output logic                     resp_valid,
   output logic [IDW-1:0]           resp_id,
   output logic [CNT_W-1:0]         resp_count,
   input  logic                     resp_ready
`ifdef SEQ_DET_SCHED_FIRSTPOS_EN
   ,output logic [KW-1:0]           resp_pos
`endif
);

   localparam logic [KW-1:0] K_LAST = KW'(DATA_W - 1);
   localparam logic [KW-1:0] D_LAST = KW'(DRAIN_CYC - 1);

   state_e              state_q, state_d;
   logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]      resp_id_q, resp_id_d;
   logic [DATA_W-1:0]   sreg_q, sreg_d;
   logic [KW-1:0]       k_q, k_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                det_clr_q, det_clr_d;
   logic                det_data_q, det_data_d;
   logic [NREQ-1:0]     gnt;
   logic [IDW-1:0]      gnt_id;
   logic                gnt_any;
   logic                count_en;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req_i    (req_valid),
      .ptr_i    (rr_ptr_q),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id),
      .any_o    (gnt_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (|req_valid) state_d = S_ARB;
         S_ARB:   state_d = gnt_any ? S_CLEAR : S_IDLE;
         S_CLEAR: state_d = S_SHIFT;
         S_SHIFT: if (k_q == K_LAST) state_d = S_DRAIN;
         S_DRAIN: if (k_q == D_LAST) state_d = S_RESP;
         S_RESP:  if (resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Detector-facing outputs are registered, so they are computed from the next state.
   always_comb begin
      req_ready  = (state_q == S_ARB) ? gnt : '0;
      resp_valid = (state_q == S_RESP);
      det_clr_d  = (state_d == S_CLEAR);
      det_data_d = (state_d == S_SHIFT) ? sreg_q[DATA_W-1] : 1'b0;
   end

   // Flags trail the driven bit by FLAG_LAT cycles; only those of real word bits count.
   assign count_en = det_flag &&
                     (((state_q == S_SHIFT) && (k_q >= KW'(FLAG_LAT))) || (state_q == S_DRAIN));

   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      resp_id_d = resp_id_q;
      sreg_d    = sreg_q;
      cnt_d     = cnt_q;
      k_d       = (state_d == state_q) ? k_q + KW'(1) : '0;
      if (state_q == S_ARB && gnt_any) begin
         sreg_d    = req_data[gnt_id*DATA_W +: DATA_W];
         resp_id_d = gnt_id;
         rr_ptr_d  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
         cnt_d     = '0;
      end
      if (state_d == S_SHIFT) sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
      if (count_en && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         resp_id_q  <= '0;
         sreg_q     <= '0;
         k_q        <= '0;
         cnt_q      <= '0;
         det_clr_q  <= 1'b1;
         det_data_q <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         resp_id_q  <= resp_id_d;
         sreg_q     <= sreg_d;
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         det_clr_q  <= det_clr_d;
         det_data_q <= det_data_d;
      end
   end

   assign det_clr    = det_clr_q;
   assign det_data   = det_data_q;
   assign resp_id    = resp_id_q;
   assign resp_count = cnt_q;

`ifdef SEQ_DET_SCHED_FIRSTPOS_EN
   logic [KW-1:0] pos_q, pos_d;
   logic [KW-1:0] flag_pos;

   assign flag_pos = (state_q == S_SHIFT) ? k_q - KW'(FLAG_LAT)
                                          : KW'(DATA_W - FLAG_LAT) + k_q;

   always_comb begin
      pos_d = pos_q;
      if (state_q == S_ARB && gnt_any) pos_d = '0;
      if (count_en && cnt_q == '0) pos_d = flag_pos;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pos_q <= '0;
      else     pos_q <= pos_d;
   end

   assign resp_pos = pos_q;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// tb/tb_seq_det_sched.sv - directed self-checking bench for seq_det_sched with detector models
module tb_seq_det_sched;
   import seq_det_pkg::SEQ_PATTERN;

   logic        clk = 1'b0;
   logic        rst;
   int          n_cmp = 0;
   int          n_fail = 0;

   logic [1:0]  req_valid_a, req_ready_a;
   logic [15:0] req_data_a;
   logic        det_clr_a, det_data_a, det_flag_a, resp_valid_a, resp_id_a, resp_ready_a;
   logic [3:0]  resp_count_a;
   logic [4:0]  hist_a;

   logic [1:0]  req_valid_s, req_ready_s;
   logic [15:0] req_data_s;
   logic        det_clr_s, det_data_s, det_flag_s, resp_valid_s, resp_id_s, resp_ready_s;
   logic [0:0]  resp_count_s;
   logic [4:0]  hist_s;
`ifdef SEQ_DET_SCHED_FIRSTPOS_EN
   logic [2:0]  resp_pos_a, resp_pos_s;
`endif

   always #5 clk = ~clk;

   seq_det_sched #(.NREQ(2), .DATA_W(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_data(req_data_a),
      .req_ready(req_ready_a), .det_clr(det_clr_a), .det_data(det_data_a),
      .det_flag(det_flag_a), .resp_valid(resp_valid_a), .resp_id(resp_id_a),
      .resp_count(resp_count_a), .resp_ready(resp_ready_a)
`ifdef SEQ_DET_SCHED_FIRSTPOS_EN
      , .resp_pos(resp_pos_a)
`endif
   );

   seq_det_sched #(.NREQ(2), .DATA_W(8), .CNT_W(1)) dut_sat (
      .clk(clk), .rst(rst), .req_valid(req_valid_s), .req_data(req_data_s),
      .req_ready(req_ready_s), .det_clr(det_clr_s), .det_data(det_data_s),
      .det_flag(det_flag_s), .resp_valid(resp_valid_s), .resp_id(resp_id_s),
      .resp_count(resp_count_s), .resp_ready(resp_ready_s)
`ifdef SEQ_DET_SCHED_FIRSTPOS_EN
      , .resp_pos(resp_pos_s)
`endif
   );

   // Detector model: bit sampled at the end of cycle t, registered flag visible in t+2.
   always @(posedge clk or posedge det_clr_a) begin
      if (det_clr_a) begin
         hist_a <= '0; det_flag_a <= 1'b0;
      end else begin
         hist_a <= {hist_a[3:0], det_data_a}; det_flag_a <= (hist_a == SEQ_PATTERN);
      end
   end

   always @(posedge clk or posedge det_clr_s) begin
      if (det_clr_s) begin
         hist_s <= '0; det_flag_s <= 1'b0;
      end else begin
         hist_s <= {hist_s[3:0], det_data_s}; det_flag_s <= (hist_s == SEQ_PATTERN);
      end
   end

   task automatic do_txn(input int id, input logic [7:0] word, output int lat, output logic rid,
                         output logic [3:0] rcnt, output logic [2:0] rpos, output bit to);
      int arb;
      arb = -1; lat = -1; to = 1'b1; rid = 1'b0; rcnt = '0; rpos = '0;
      req_data_a[id*8 +: 8] = word;
      req_valid_a[id] = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (arb >= 0 && c == arb + 1) req_valid_a[id] = 1'b0;
         if (arb < 0 && req_ready_a[id]) arb = c;
         if (resp_valid_a) begin
            lat = c - arb; rid = resp_id_a; rcnt = resp_count_a; to = 1'b0;
`ifdef SEQ_DET_SCHED_FIRSTPOS_EN
            rpos = resp_pos_a;
`endif
            break;
         end
      end
      req_valid_a[id] = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (req_ready_a !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b want 00", req_ready_a); end
      n_cmp++; if (det_clr_a !== 1'b1) begin n_fail++; $display("FAIL rst_det_clr: got %b want 1", det_clr_a); end
      n_cmp++; if (det_data_a !== 1'b0) begin n_fail++; $display("FAIL rst_det_data: got %b want 0", det_data_a); end
      n_cmp++; if (resp_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid_a); end
      n_cmp++; if (resp_id_a !== 1'b0) begin n_fail++; $display("FAIL rst_resp_id: got %b want 0", resp_id_a); end
      n_cmp++; if (resp_count_a !== 4'd0) begin n_fail++; $display("FAIL rst_resp_count: got %0d want 0", resp_count_a); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (det_clr_a !== 1'b0) begin n_fail++; $display("FAIL rel_det_clr: got %b want 0", det_clr_a); end
      n_cmp++; if (det_clr_s !== 1'b0) begin n_fail++; $display("FAIL rel_det_clr_sat: got %b want 0", det_clr_s); end
   endtask

   task automatic test_basic;
      int lat; logic rid; logic [3:0] rcnt; logic [2:0] rpos; bit to;
      resp_ready_a = 1'b1;
      do_txn(0, 8'b10010010, lat, rid, rcnt, rpos, to);
      @(negedge clk);
      n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", to); end
      n_cmp++; if (lat !== 12) begin n_fail++; $display("FAIL basic_latency: got %0d want 12", lat); end
      n_cmp++; if (rid !== 1'b0) begin n_fail++; $display("FAIL basic_id: got %0d want 0", rid); end
      n_cmp++; if (rcnt !== 4'd2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", rcnt); end
`ifdef SEQ_DET_SCHED_FIRSTPOS_EN
      n_cmp++; if (rpos !== 3'd4) begin n_fail++; $display("FAIL basic_pos: got %0d want 4", rpos); end
`endif
   endtask

   task automatic test_counts;
      logic [7:0] words [3] = '{8'h00, 8'b00010010, 8'b01001001};
      logic [3:0] ecnt [3]  = '{4'd0, 4'd1, 4'd1};
      logic [2:0] epos [3]  = '{3'd0, 3'd7, 3'd5};
      int lat; logic rid; logic [3:0] rcnt; logic [2:0] rpos; bit to;
      for (int i = 0; i < 3; i++) begin
         do_txn(1, words[i], lat, rid, rcnt, rpos, to);
         @(negedge clk);
         n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL cnt_timeout[%0d]: got %b want 0", i, to); end
         n_cmp++; if (rid !== 1'b1) begin n_fail++; $display("FAIL cnt_id[%0d]: got %0d want 1", i, rid); end
         n_cmp++; if (rcnt !== ecnt[i]) begin n_fail++; $display("FAIL cnt_count[%0d]: got %0d want %0d", i, rcnt, ecnt[i]); end
`ifdef SEQ_DET_SCHED_FIRSTPOS_EN
         n_cmp++; if (rpos !== epos[i]) begin n_fail++; $display("FAIL cnt_pos[%0d]: got %0d want %0d", i, rpos, epos[i]); end
`endif
      end
   endtask

   task automatic test_back_to_back;
      int ng, nr, bad_pulse, last_resp, gap;
      bit drop;
      logic [1:0] prev;
      int order [4];
      logic rid [4];
      logic [3:0] rcnt [4];
      ng = 0; nr = 0; bad_pulse = 0; last_resp = -100; gap = -1; drop = 1'b0; prev = '0;
      for (int i = 0; i < 4; i++) begin order[i] = -1; rid[i] = 1'b0; rcnt[i] = '0; end
      resp_ready_a = 1'b1;
      req_data_a = {8'b00010010, 8'b10010010};
      req_valid_a = 2'b11;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (drop) req_valid_a = 2'b00;
         if (req_ready_a != 2'b00) begin
            if (prev != 2'b00 || !$onehot(req_ready_a)) bad_pulse++;
            if (ng < 4) order[ng] = req_ready_a[1] ? 1 : 0;
            if (ng == 1) gap = c - last_resp;
            ng++;
            if (ng == 4) drop = 1'b1;
         end
         prev = req_ready_a;
         if (resp_valid_a) begin
            if (nr == 0) last_resp = c;
            rid[nr] = resp_id_a; rcnt[nr] = resp_count_a; nr++;
            if (nr == 4) break;
         end
      end
      req_valid_a = 2'b00;
      @(negedge clk);
      n_cmp++; if (nr !== 4) begin n_fail++; $display("FAIL b2b_responses: got %0d want 4", nr); end
      n_cmp++; if (ng !== 4) begin n_fail++; $display("FAIL b2b_grants: got %0d want 4", ng); end
      n_cmp++; if (bad_pulse !== 0) begin n_fail++; $display("FAIL b2b_pulse: got %0d bad want 0", bad_pulse); end
      n_cmp++; if (gap !== 2) begin n_fail++; $display("FAIL b2b_gap: got %0d want 2", gap); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (order[i] !== i % 2) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, order[i], i % 2); end
         n_cmp++; if (rid[i] !== 1'((i % 2))) begin n_fail++; $display("FAIL b2b_id[%0d]: got %0d want %0d", i, rid[i], i % 2); end
         n_cmp++; if (rcnt[i] !== ((i % 2) ? 4'd1 : 4'd2)) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, rcnt[i], (i % 2) ? 1 : 2); end
      end
   endtask

   task automatic test_backpressure;
      int lat; logic rid; logic [3:0] rcnt; logic [2:0] rpos; bit to;
      resp_ready_a = 1'b0;
      do_txn(0, 8'b10010010, lat, rid, rcnt, rpos, to);
      n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b want 0", to); end
      req_data_a[15:8] = 8'h00;
      req_valid_a[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++; if (resp_valid_a !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, resp_valid_a); end
         n_cmp++; if (resp_id_a !== 1'b0) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d want 0", i, resp_id_a); end
         n_cmp++; if (resp_count_a !== 4'd2) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d want 2", i, resp_count_a); end
         n_cmp++; if (req_ready_a !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 00", i, req_ready_a); end
      end
      resp_ready_a = 1'b1;
      @(negedge clk);
      n_cmp++; if (resp_valid_a !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", resp_valid_a); end
      do_txn(1, 8'h00, lat, rid, rcnt, rpos, to);
      @(negedge clk);
      n_cmp++; if (lat !== 12) begin n_fail++; $display("FAIL bp_next_latency: got %0d want 12", lat); end
      n_cmp++; if (rid !== 1'b1) begin n_fail++; $display("FAIL bp_next_id: got %0d want 1", rid); end
   endtask

   task automatic test_saturate;
      int arb; bit got; logic [0:0] cnt;
      arb = -1; got = 1'b0; cnt = '0;
      resp_ready_s = 1'b1;
      req_data_s[7:0] = 8'b10010010;
      req_valid_s[0] = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (arb >= 0 && c == arb + 1) req_valid_s[0] = 1'b0;
         if (arb < 0 && req_ready_s[0]) arb = c;
         if (resp_valid_s) begin cnt = resp_count_s; got = 1'b1; break; end
      end
      req_valid_s[0] = 1'b0;
      @(negedge clk);
      n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL sat_timeout: got %b want 1", got); end
      n_cmp++; if (cnt !== 1'b1) begin n_fail++; $display("FAIL sat_count: got %0d want 1", cnt); end
   endtask

   task automatic test_reset_mid;
      int arb, seen;
      int lat; logic rid; logic [3:0] rcnt; logic [2:0] rpos; bit to;
      arb = -1; seen = 0;
      resp_ready_a = 1'b1;
      req_data_a[15:8] = 8'b10010010;
      req_valid_a[1] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (arb >= 0 && c == arb + 1) req_valid_a[1] = 1'b0;
         if (arb < 0 && req_ready_a[1]) arb = c;
         if (arb >= 0 && c == arb + 5) break;
      end
      req_valid_a = 2'b00;
      n_cmp++; if (arb < 0) begin n_fail++; $display("FAIL mid_grant: got none want grant"); end
      rst = 1'b1;
      #1;
      n_cmp++; if (det_clr_a !== 1'b1) begin n_fail++; $display("FAIL mid_det_clr: got %b want 1", det_clr_a); end
      n_cmp++; if (det_data_a !== 1'b0) begin n_fail++; $display("FAIL mid_det_data: got %b want 0", det_data_a); end
      n_cmp++; if (resp_id_a !== 1'b0) begin n_fail++; $display("FAIL mid_resp_id: got %0d want 0", resp_id_a); end
      n_cmp++; if (resp_count_a !== 4'd0) begin n_fail++; $display("FAIL mid_resp_count: got %0d want 0", resp_count_a); end
      n_cmp++; if (resp_valid_a !== 1'b0) begin n_fail++; $display("FAIL mid_resp_valid: got %b want 0", resp_valid_a); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (resp_valid_a) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_resp: got %0d responses want 0", seen); end
      do_txn(0, 8'b10010010, lat, rid, rcnt, rpos, to);
      @(negedge clk);
      n_cmp++; if (lat !== 12) begin n_fail++; $display("FAIL mid_after_latency: got %0d want 12", lat); end
      n_cmp++; if (rcnt !== 4'd2) begin n_fail++; $display("FAIL mid_after_count: got %0d want 2", rcnt); end
`ifdef SEQ_DET_SCHED_FIRSTPOS_EN
      n_cmp++; if (rpos !== 3'd4) begin n_fail++; $display("FAIL mid_after_pos: got %0d want 4", rpos); end
`endif
   endtask

   initial begin
      rst = 1'b1;
      req_valid_a = '0; req_data_a = '0; resp_ready_a = 1'b1;
      req_valid_s = '0; req_data_s = '0; resp_ready_s = 1'b1;
      test_reset;
      test_basic;
      test_counts;
      test_back_to_back;
      test_backpressure;
      test_saturate;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
